// File: rtl/gdsp_pkg.sv
// Shared DSP-domain definitions: noise level table and the sweep sequencer state encoding.
package gdsp_pkg;

  localparam int NOISE_MAG_WIDTH = 8;
  localparam int NOISE_LEVELS    = 4;

  typedef logic [NOISE_MAG_WIDTH-1:0] noise_mag_t;

  localparam noise_mag_t NOISE_LUT [NOISE_LEVELS] = '{8'd0, 8'd20, 8'd50, 8'd100};

  typedef enum logic [2:0] {
    ST_MANUAL  = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_DWELL   = 3'd3,
    ST_ADVANCE = 3'd4
  } sweep_state_t;

  // Level index wraps naturally with the 2-bit width (3 -> 0).
  function automatic logic [1:0] next_level(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

endpackage

// File: rtl/noise_sweep_ctrl_lock_qualifier.sv
// Lock persistence filter: output follows demod_lock only after LOCK_HYST consecutive
// cycles of disagreement. Compiled only when SWEEP_LOCK_HYST_EN is defined.
`ifdef SWEEP_LOCK_HYST_EN
module lock_qualifier #(
  parameter int LOCK_HYST = 256
) (
  input  logic clk_dsp,
  input  logic sys_rst_n,
  input  logic lock_raw,
  output logic lock_qual
);

  localparam int CNT_W = $clog2(LOCK_HYST);

  logic [CNT_W-1:0] cnt_reg;
  logic             qual_reg;

  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_reg  <= '0;
      qual_reg <= 1'b0;
    end else if (lock_raw != qual_reg) begin
      if (cnt_reg == CNT_W'(LOCK_HYST - 1)) begin
        qual_reg <= lock_raw;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  assign lock_qual = qual_reg;

endmodule
`endif

// File: rtl/noise_sweep_ctrl.sv
// Noise level sequencer: manual stepping or automatic settle/acquire/dwell sweep with
// per-level acquisition reports. SWEEP_LOCK_HYST_EN adds a lock persistence filter.
module noise_sweep_ctrl
  import gdsp_pkg::*;
#(
  parameter int SETTLE_CYC  = 1024,
  parameter int ACQ_TIMEOUT = 1048575,
  parameter int DWELL_SYMS  = 65536,
  parameter int ACQ_CNT_W   = 20
) (
  input  logic                       clk_dsp,
  input  logic                       sys_rst_n,
  input  logic                       auto_en,
  input  logic                       btn_press,
  input  logic                       demod_lock,
  input  logic                       demod_valid,
  output logic [1:0]                 noise_sel,
  output logic [NOISE_MAG_WIDTH-1:0] noise_magnitude,
  output logic [2:0]                 sweep_state,
  output logic                       report_valid,
  output logic [ACQ_CNT_W-1:0]       acq_cycles,
  output logic                       acq_timeout
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int SYM_W    = $clog2(DWELL_SYMS + 1);

  sweep_state_t         state_reg, state_next;
  logic [1:0]           sel_reg, sel_next;
  noise_mag_t           mag_reg;
  logic [SETTLE_W-1:0]  settle_cnt_reg, settle_cnt_next;
  logic [ACQ_CNT_W-1:0] acq_cnt_reg, acq_cnt_next;
  logic [SYM_W-1:0]     sym_cnt_reg, sym_cnt_next;
  logic                 rep_valid_reg, rep_valid_next;
  logic [ACQ_CNT_W-1:0] acq_cycles_reg, acq_cycles_next;
  logic                 acq_timeout_reg, acq_timeout_next;
  logic                 lock_int;

`ifdef SWEEP_LOCK_HYST_EN
  localparam int LOCK_HYST = 256;
  lock_qualifier #(.LOCK_HYST(LOCK_HYST)) u_lock_qualifier (
    .clk_dsp   (clk_dsp),
    .sys_rst_n (sys_rst_n),
    .lock_raw  (demod_lock),
    .lock_qual (lock_int)
  );
`else
  assign lock_int = demod_lock;
`endif

  always_comb begin
    state_next       = state_reg;
    sel_next         = sel_reg;
    settle_cnt_next  = settle_cnt_reg;
    acq_cnt_next     = acq_cnt_reg;
    sym_cnt_next     = sym_cnt_reg;
    rep_valid_next   = 1'b0;
    acq_cycles_next  = acq_cycles_reg;
    acq_timeout_next = acq_timeout_reg;

    if (state_reg == ST_MANUAL) begin
      if (auto_en) begin
        state_next      = ST_SETTLE;
        settle_cnt_next = '0;
      end else if (btn_press) begin
        sel_next = next_level(sel_reg);
      end
    // Leaving auto mode beats a skip request, which beats any lock/timeout/dwell event.
    end else if (!auto_en) begin
      state_next      = ST_MANUAL;
      settle_cnt_next = '0;
      acq_cnt_next    = '0;
      sym_cnt_next    = '0;
    end else if (btn_press) begin
      state_next = ST_ADVANCE;
    end else begin
      case (state_reg)
        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_W'(SETTLE_CYC - 1)) begin
            state_next   = ST_ACQUIRE;
            acq_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + 1'b1;
          end
        end
        ST_ACQUIRE: begin
          if (lock_int) begin
            state_next       = ST_DWELL;
            sym_cnt_next     = '0;
            rep_valid_next   = 1'b1;
            acq_cycles_next  = acq_cnt_reg;
            acq_timeout_next = 1'b0;
          end else if (acq_cnt_reg == ACQ_CNT_W'(ACQ_TIMEOUT)) begin
            state_next       = ST_ADVANCE;
            rep_valid_next   = 1'b1;
            acq_cycles_next  = ACQ_CNT_W'(ACQ_TIMEOUT);
            acq_timeout_next = 1'b1;
          end else begin
            acq_cnt_next = acq_cnt_reg + 1'b1;
          end
        end
        ST_DWELL: begin
          if (!lock_int) begin
            state_next   = ST_ACQUIRE;
            acq_cnt_next = '0;
            sym_cnt_next = '0;
          end else if (demod_valid) begin
            if (sym_cnt_reg == SYM_W'(DWELL_SYMS - 1)) begin
              state_next = ST_ADVANCE;
            end else begin
              sym_cnt_next = sym_cnt_reg + 1'b1;
            end
          end
        end
        ST_ADVANCE: begin
          state_next      = ST_SETTLE;
          sel_next        = next_level(sel_reg);
          settle_cnt_next = '0;
        end
        default: state_next = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk_dsp or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= ST_MANUAL;
      sel_reg         <= '0;
      mag_reg         <= '0;
      settle_cnt_reg  <= '0;
      acq_cnt_reg     <= '0;
      sym_cnt_reg     <= '0;
      rep_valid_reg   <= 1'b0;
      acq_cycles_reg  <= '0;
      acq_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sel_reg         <= sel_next;
      mag_reg         <= NOISE_LUT[sel_reg];
      settle_cnt_reg  <= settle_cnt_next;
      acq_cnt_reg     <= acq_cnt_next;
      sym_cnt_reg     <= sym_cnt_next;
      rep_valid_reg   <= rep_valid_next;
      acq_cycles_reg  <= acq_cycles_next;
      acq_timeout_reg <= acq_timeout_next;
    end
  end

  assign noise_sel       = sel_reg;
  assign noise_magnitude = mag_reg;
  assign sweep_state     = state_reg;
  assign report_valid    = rep_valid_reg;
  assign acq_cycles      = acq_cycles_reg;
  assign acq_timeout     = acq_timeout_reg;

endmodule

// File: tb/tb_noise_sweep_ctrl.sv
// Scoreboard bench for noise_sweep_ctrl: stimulus pushes expected level changes and
// reports (value + arrival cycle); a negedge monitor pops and compares them.
module tb_noise_sweep_ctrl;

  localparam int SC = 16;
  localparam int AT = 4096;
  localparam int DS = 128;
  localparam int CW = 20;
`ifdef SWEEP_LOCK_HYST_EN
  localparam int HYST = 256;
`endif

  logic          clk_dsp = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          auto_en = 1'b0;
  logic          btn_press = 1'b0;
  logic          demod_lock = 1'b0;
  logic          demod_valid = 1'b0;
  logic [1:0]    noise_sel;
  logic [7:0]    noise_magnitude;
  logic [2:0]    sweep_state;
  logic          report_valid;
  logic [CW-1:0] acq_cycles;
  logic          acq_timeout;

  noise_sweep_ctrl #(
    .SETTLE_CYC(SC), .ACQ_TIMEOUT(AT), .DWELL_SYMS(DS), .ACQ_CNT_W(CW)
  ) dut (
    .clk_dsp         (clk_dsp),
    .sys_rst_n       (sys_rst_n),
    .auto_en         (auto_en),
    .btn_press       (btn_press),
    .demod_lock      (demod_lock),
    .demod_valid     (demod_valid),
    .noise_sel       (noise_sel),
    .noise_magnitude (noise_magnitude),
    .sweep_state     (sweep_state),
    .report_valid    (report_valid),
    .acq_cycles      (acq_cycles),
    .acq_timeout     (acq_timeout)
  );

  always #5 clk_dsp = ~clk_dsp;

  int cyc = 0;
  always @(posedge clk_dsp) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int lut [4] = '{0, 20, 50, 100};

  typedef struct { int val; int cyc; } sel_exp_t;
  typedef struct { int acq; int to; int cyc; } rep_exp_t;
  sel_exp_t sel_q[$];
  rep_exp_t rep_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every report and every level change must match the head of its queue.
  bit       mon_en = 1'b0;
  int       prev_sel = 0;
  bit       mag_pend = 1'b0;
  int       mag_exp = 0;
  rep_exp_t re;
  sel_exp_t se;

  always @(negedge clk_dsp) begin
    if (mon_en) begin
      if (mag_pend) begin
        chk("noise_magnitude", noise_magnitude, mag_exp);
        mag_pend = 1'b0;
      end
      if (report_valid !== 1'b0) begin
        if (rep_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL report_unexpected: got acq_cycles=%0d acq_timeout=%0d expected no report (cycle %0d)",
                   acq_cycles, acq_timeout, cyc);
        end else begin
          re = rep_q.pop_front();
          chk("acq_cycles", acq_cycles, re.acq);
          chk("acq_timeout", acq_timeout, re.to);
          chk("report_cycle", cyc, re.cyc);
        end
      end
      if (int'(noise_sel) != prev_sel) begin
        chk("noise_magnitude_lag", noise_magnitude, lut[prev_sel]);
        if (sel_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sel_unexpected: got noise_sel=%0d expected %0d (cycle %0d)", noise_sel, prev_sel, cyc);
        end else begin
          se = sel_q.pop_front();
          chk("noise_sel", noise_sel, se.val);
          chk("noise_sel_cycle", cyc, se.cyc);
        end
        prev_sel = int'(noise_sel);
        mag_exp  = lut[prev_sel];
        mag_pend = 1'b1;
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_dsp);
  endtask

  task automatic push_sel(input int v, input int c);
    sel_exp_t e;
    e.val = v;
    e.cyc = c;
    sel_q.push_back(e);
  endtask

  task automatic push_rep(input int a, input int t, input int c);
    rep_exp_t e;
    e.acq = a;
    e.to  = t;
    e.cyc = c;
    rep_q.push_back(e);
  endtask

  task automatic pulse_valids(input int n, output int last);
    last = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk_dsp);
      demod_valid = 1'b1;
      last = cyc;
      @(negedge clk_dsp);
      demod_valid = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, sweep_state, 0);
    chk({tag, "_sel"}, noise_sel, 0);
    chk({tag, "_mag"}, noise_magnitude, 0);
    chk({tag, "_report_valid"}, report_valid, 0);
    chk({tag, "_acq_cycles"}, acq_cycles, 0);
    chk({tag, "_acq_timeout"}, acq_timeout, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  int level;
  int a0;
  int d;
  int last;
  int t;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_dsp);
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk_dsp);
    chk_reset_outputs("post_reset");
    prev_sel = 0;
    mon_en = 1'b1;

    // Manual stepping: 5 presses -> 1,2,3,0,1
    level = 0;
    for (int i = 0; i < 5; i++) begin
      btn_press = 1'b1;
      level = (level + 1) % 4;
      push_sel(level, cyc + 1);
      @(negedge clk_dsp);
      btn_press = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk_dsp);
    end

    auto_en = 1'b1;
    a0 = cyc + 1 + SC;

`ifndef SWEEP_LOCK_HYST_EN
    // Lock 500 cycles after settle exit, full dwell, advance
    d = 500;
    wait_until(a0 + d);
    demod_lock = 1'b1;
    push_rep(d, 0, a0 + d + 1);
    @(negedge clk_dsp);
    chk("state_dwell", sweep_state, 3);
    pulse_valids(DS, last);
    level = (level + 1) % 4;
    push_sel(level, last + 2);
    demod_lock = 1'b0;
    a0 = last + 2 + SC;

    // Lock drop after 100 symbols, re-lock 50 cycles later, full dwell afresh
    d = $urandom_range(1, 600);
    wait_until(a0 + d);
    demod_lock = 1'b1;
    push_rep(d, 0, a0 + d + 1);
    @(negedge clk_dsp);
    pulse_valids(100, last);
    demod_lock = 1'b0;
    t = cyc;
    @(negedge clk_dsp);
    chk("state_reacquire", sweep_state, 2);
    wait_until(t + 1 + 50);
    demod_lock = 1'b1;
    push_rep(50, 0, t + 52);
    @(negedge clk_dsp);
    pulse_valids(DS, last);
    level = (level + 1) % 4;
    push_sel(level, last + 2);
    demod_lock = 1'b0;
    a0 = last + 2 + SC;
`endif

    // Four timeouts with lock held low; level wraps through 3 -> 0
    for (int k = 0; k < 4; k++) begin
      level = (level + 1) % 4;
      push_rep(AT, 1, a0 + AT + 1);
      push_sel(level, a0 + AT + 2);
      wait_until(a0 + AT + 2);
      a0 = a0 + AT + 2 + SC;
    end

`ifndef SWEEP_LOCK_HYST_EN
    // Lock and skip together: skip wins, no report
    d = $urandom_range(1, 300);
    wait_until(a0 + d);
    demod_lock = 1'b1;
    btn_press = 1'b1;
    level = (level + 1) % 4;
    push_sel(level, a0 + d + 2);
    @(negedge clk_dsp);
    chk("state_skip_advance", sweep_state, 4);
    demod_lock = 1'b0;
    btn_press = 1'b0;
    a0 = a0 + d + 2 + SC;

    // Lock and auto_en drop together: manual wins, level held, no report
    d = $urandom_range(1, 300);
    wait_until(a0 + d);
    demod_lock = 1'b1;
    auto_en = 1'b0;
    @(negedge clk_dsp);
    chk("state_exit_manual", sweep_state, 0);
    chk("sel_held_on_exit", noise_sel, level);
    demod_lock = 1'b0;
    repeat (3) @(negedge clk_dsp);
`else
    // 100-cycle glitch ignored; sustained lock reports at start + HYST
    wait_until(a0 + 10);
    demod_lock = 1'b1;
    wait_until(a0 + 110);
    demod_lock = 1'b0;
    wait_until(a0 + 150);
    chk("state_glitch_ignored", sweep_state, 2);
    t = a0 + 200;
    wait_until(t);
    demod_lock = 1'b1;
    push_rep(t - a0 + HYST, 0, t + HYST + 1);
    wait_until(t + HYST + 1);
    chk("state_hyst_dwell", sweep_state, 3);
    wait_until(t + 300);
    demod_lock = 1'b0;
    auto_en = 1'b0;
    @(negedge clk_dsp);
    chk("state_exit_manual", sweep_state, 0);
    chk("sel_held_on_exit", noise_sel, level);
    repeat (3) @(negedge clk_dsp);
`endif

    // Asynchronous reset mid-sweep
    auto_en = 1'b1;
    t = cyc;
    wait_until(t + 1 + SC + 20);
    chk("state_before_reset", sweep_state, 2);
    mon_en = 1'b0;
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk_dsp);
    auto_en = 1'b0;
    sys_rst_n = 1'b1;
    prev_sel = int'(noise_sel);
    mon_en = 1'b1;
    repeat (5) @(negedge clk_dsp);
    chk("state_after_reset", sweep_state, 0);

    chk("sel_queue_empty", sel_q.size(), 0);
    chk("report_queue_empty", rep_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_sweep_ctrl.md
Name: noise_sweep_ctrl

Overview:
Sequencer for the AWGN channel's noise_magnitude in the clk_dsp domain; it replaces the free-running S1 cycler in the top level. Two modes, selected by auto_en:
- Manual: a debounced button press steps the noise level.
- Auto: sweeps levels 0→20→50→100. At each level it settles, waits for Costas/Gardner lock, then dwells a fixed number of demodulated symbols.
For each level it reports acquisition time (cycles to lock) or timeout, for LED/HDMI overlay and bench measurement.

Parameters:
SETTLE_CYC, 1024, cycles after a level change during which demod_lock is ignored (filter/loop flush)
ACQ_TIMEOUT, 1048575, max cycles waited in ACQUIRE before declaring timeout
DWELL_SYMS, 65536, demod_valid pulses counted in DWELL before advancing
ACQ_CNT_W, 20, width of acquisition counter and acq_cycles output

Ports:
clk_dsp  in  1  DSP clock, 27 MHz
sys_rst_n  in  1  reset, asynchronous, active-low
auto_en  in  1  level; 1 = auto sweep, 0 = manual
btn_press  in  1  single-cycle pulse from the debouncer, synchronous to clk_dsp
demod_lock  in  1  receiver lock indicator
demod_valid  in  1  demodulated symbol strobe
noise_sel  out  2  current level index 0..3
noise_magnitude  out  NOISE_MAG_WIDTH  table value for noise_sel, registered
sweep_state  out  3  encoded FSM state (for LEDs/debug)
report_valid  out  1  one-cycle pulse when a level's acquisition result is final
acq_cycles  out  ACQ_CNT_W  cycles from SETTLE exit to lock; saturates at ACQ_TIMEOUT
acq_timeout  out  1  1 = level failed to lock within ACQ_TIMEOUT; valid with report_valid

Behaviour:
- Reset values:
  - noise_sel=0, noise_magnitude=0, sweep_state=MANUAL
  - report_valid=0, acq_cycles=0, acq_timeout=0
  - all counters 0
- noise_magnitude is registered from the package table NOISE_LUT[noise_sel]; it updates 1 cycle after noise_sel.
- States (encoding): MANUAL=0, SETTLE=1, ACQUIRE=2, DWELL=3, ADVANCE=4.
- MANUAL:
  - btn_press → noise_sel+1, wrapping mod 4 (3→0).
  - auto_en=1 → SETTLE, with the settle counter cleared and noise_sel unchanged.
- SETTLE:
  - Counts SETTLE_CYC cycles; demod_lock is ignored.
  - At count SETTLE_CYC-1 → ACQUIRE; acq counter cleared.
- ACQUIRE:
  - acq counter +1 per cycle.
  - demod_lock=1 → DWELL. report_valid=1 for one cycle, acq_cycles=counter, acq_timeout=0.
  - Counter reaching ACQ_TIMEOUT → ADVANCE. report_valid=1, acq_cycles=ACQ_TIMEOUT, acq_timeout=1.
- DWELL:
  - Symbol counter +1 per demod_valid.
  - At DWELL_SYMS → ADVANCE.
  - demod_lock falling → ACQUIRE; acq and symbol counters cleared; no report is issued.
- ADVANCE: single cycle; noise_sel+1 mod 4 → SETTLE.
- auto_en=0 in any auto state → MANUAL next cycle.
  - Counters are cleared and noise_sel is held.
  - A pending report is dropped; report_valid is never asserted on the exit cycle.
- btn_press in any auto state → ADVANCE next cycle (skip level); no report for the skipped level.
- Priority when events coincide in the same cycle: auto_en=0 > btn_press > lock/timeout/dwell-complete.
  - Example: lock and btn_press together → ADVANCE, no report.
- acq_cycles and acq_timeout hold their values between reports.
- Reset asserted mid-sweep returns everything to the reset values asynchronously.

Optional Feature:
Macro: SWEEP_LOCK_HYST_EN.
- Defined:
  - demod_lock is qualified internally by a lock-hysteresis filter with localparam LOCK_HYST=256.
  - Qualified lock rises only after demod_lock has been high for 256 consecutive cycles. acq_cycles then includes those 256 cycles.
  - Qualified lock falls only after demod_lock has been low for 256 consecutive cycles.
  - The qualified lock replaces raw demod_lock in ACQUIRE and DWELL.
- Undefined: raw demod_lock is used directly; the filter is not instantiated.

Decomposition:
- gdsp_pkg additions:
  - NOISE_LUT constant array {0,20,50,100} of NOISE_MAG_WIDTH
  - sweep_state_t enum (3-bit)
  - NOISE_LEVELS=4
- Sub-module lock_qualifier: persistence counter, compiled in only under SWEEP_LOCK_HYST_EN.

Test Plan:
1. Reset, auto_en=0, 5 btn_press pulses → noise_sel 1,2,3,0,1; noise_magnitude 20,50,100,0,20, each one cycle after noise_sel.
2. auto_en=1, demod_lock rises 500 cycles after SETTLE exit, DWELL_SYMS valids supplied → report_valid with acq_cycles=500, acq_timeout=0; noise_sel advances 1→2 after the final valid.
3. auto_en=1, demod_lock held 0 (ACQ_TIMEOUT reduced to 4096) → report acq_cycles=4096, acq_timeout=1; ADVANCE; level wraps 3→0 after four timeouts.
4. Lock drop in DWELL after 100 symbols, re-lock 50 cycles later → state returns to ACQUIRE, second report acq_cycles=50, full DWELL_SYMS counted afresh.
5. Simultaneous demod_lock rise and btn_press in ACQUIRE → no report_valid, ADVANCE next cycle; auto_en=0 on the same cycle instead → MANUAL, noise_sel unchanged.
6. With SWEEP_LOCK_HYST_EN defined, 100-cycle lock glitch → no transition; lock held 300 cycles → report at glitch-free start+256.
